// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer datapath blocks.
package fc_pkg;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } fc_ser_state_e;

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned fc_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_vector_serializer_if.sv
// Upstream vector handshake plus downstream FIFO write port of the serializer.
interface fc_vector_serializer_if #(
  parameter int unsigned WORD_SIZE    = 8,
  parameter int unsigned LAYER_HEIGHT = 4,
  parameter int unsigned LANES        = 1
);
  logic                                   valid_i;
  logic                                   ready_o;
  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i;
  logic                                   wen_o;
  logic                                   full_i;
  logic [LANES-1:0][WORD_SIZE-1:0]        data_o;
  logic                                   last_o;

  modport slave (
    input  valid_i, data_i, full_i,
    output ready_o, wen_o, data_o, last_o
  );

  modport master (
    output valid_i, data_i, full_i,
    input  ready_o, wen_o, data_o, last_o
  );
endinterface

// File: rtl/fc_beat_counter.sv
// Wrapping beat counter with synchronous clear (priority) and enable.
module fc_beat_counter
  import fc_pkg::*;
#(
  parameter int unsigned COUNT = 4,
  localparam int unsigned CW   = fc_cnt_width(COUNT)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          last_o
);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_d;

  assign last_o  = (r_count == CW'(COUNT - 1));
  assign count_o = r_count;

  always_comb begin
    w_count_d = r_count;
    if (clr_i) begin
      w_count_d = '0;
    end else if (en_i) begin
      w_count_d = last_o ? '0 : r_count + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

endmodule

// File: rtl/fc_vector_serializer.sv
// Captures a full layer vector and drains it into a FIFO, LANES words per write beat.
module fc_vector_serializer
  import fc_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = 8,
  parameter int unsigned LAYER_HEIGHT = 4,
  parameter int unsigned LANES        = 1,
  parameter bit          MSW_FIRST    = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  fc_vector_serializer_if.slave bus,
  output logic                  busy_o
);

  localparam int unsigned BEATS = LAYER_HEIGHT / LANES;
  localparam int unsigned CW    = fc_cnt_width(BEATS);
  localparam int unsigned IW    = fc_cnt_width(LAYER_HEIGHT);

  if ((LAYER_HEIGHT < 1) || (LANES < 1) || ((LAYER_HEIGHT % LANES) != 0)) begin : g_bad_cfg
    $error("fc_vector_serializer: LANES must divide LAYER_HEIGHT");
  end

  fc_ser_state_e                          r_state;
  fc_ser_state_e                          w_state_d;
  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] r_vec;
  logic                                   w_load;
  logic                                   w_clr;
  logic                                   w_en;
  logic                                   w_ready;
  logic [CW-1:0]                          w_count;
  logic                                   w_cnt_last;
  logic [CW-1:0]                          w_beat;

  fc_beat_counter #(
    .COUNT(BEATS)
  ) u_beat_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr_i  (w_clr),
    .en_i   (w_en),
    .count_o(w_count),
    .last_o (w_cnt_last)
  );

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_clr     = 1'b0;
    w_en      = 1'b0;
    w_ready   = 1'b0;
    bus.wen_o = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.valid_i) begin
          w_load    = 1'b1;
          w_clr     = 1'b1;
          w_state_d = SEND;
        end
      end
      SEND: begin
        bus.wen_o = !bus.full_i;
        w_en      = !bus.full_i;
        // Final beat leaving this cycle frees the register for a same-edge accept.
        if (w_cnt_last && !bus.full_i) begin
          w_ready = 1'b1;
          if (bus.valid_i) begin
            w_load = 1'b1;
            w_clr  = 1'b1;
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Reset holds the state in IDLE, so only ready needs explicit gating.
  assign bus.ready_o = w_ready & reset_i;
  assign busy_o      = (r_state == SEND);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_vec <= bus.data_i;
      end
    end
  end

  assign w_beat = MSW_FIRST ? (CW'(BEATS - 1) - w_count) : w_count;

  always_comb begin
    logic [IW-1:0] w_idx;
    bus.data_o = '0;
    bus.last_o = 1'b0;
    w_idx      = '0;
    if (r_state == SEND) begin
      bus.last_o = w_cnt_last;
      for (int l = 0; l < int'(LANES); l++) begin
        w_idx         = IW'(int'(w_beat) * int'(LANES) + l);
        bus.data_o[l] = r_vec[w_idx];
      end
    end
  end

endmodule

// File: tb/tb_fc_vector_serializer.sv
// Scoreboard bench: four serializer configurations share one clock and reset.
module tb_fc_vector_serializer;

  logic clk;
  logic rst_n;
  logic busy_a, busy_b, busy_c, busy_d;

  int n_vec = 0;
  int n_err = 0;

  logic [32:0] q_a[$];
  logic [32:0] q_b[$];
  logic [32:0] q_c[$];
  logic [32:0] q_d[$];

  fc_vector_serializer_if #(.WORD_SIZE(8), .LAYER_HEIGHT(4), .LANES(1)) if_a ();
  fc_vector_serializer_if #(.WORD_SIZE(8), .LAYER_HEIGHT(4), .LANES(1)) if_b ();
  fc_vector_serializer_if #(.WORD_SIZE(8), .LAYER_HEIGHT(4), .LANES(2)) if_c ();
  fc_vector_serializer_if #(.WORD_SIZE(8), .LAYER_HEIGHT(4), .LANES(4)) if_d ();

  fc_vector_serializer #(.WORD_SIZE(8), .LAYER_HEIGHT(4), .LANES(1), .MSW_FIRST(1'b0)) u_a (
    .clk_i(clk), .reset_i(rst_n), .bus(if_a), .busy_o(busy_a)
  );
  fc_vector_serializer #(.WORD_SIZE(8), .LAYER_HEIGHT(4), .LANES(1), .MSW_FIRST(1'b1)) u_b (
    .clk_i(clk), .reset_i(rst_n), .bus(if_b), .busy_o(busy_b)
  );
  fc_vector_serializer #(.WORD_SIZE(8), .LAYER_HEIGHT(4), .LANES(2), .MSW_FIRST(1'b0)) u_c (
    .clk_i(clk), .reset_i(rst_n), .bus(if_c), .busy_o(busy_c)
  );
  fc_vector_serializer #(.WORD_SIZE(8), .LAYER_HEIGHT(4), .LANES(4), .MSW_FIRST(1'b0)) u_d (
    .clk_i(clk), .reset_i(rst_n), .bus(if_d), .busy_o(busy_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic got, input logic exp);
    check(name, 64'(got), 64'(exp));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitors: every write strobe pops one expected {last, data} entry.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && if_a.wen_o) begin
      if (q_a.size() == 0) check("a_unexpected_write", 64'(if_a.data_o), 64'hffff_ffff);
      else begin
        e = q_a.pop_front();
        check("a_beat", 64'({if_a.last_o, 32'(if_a.data_o)}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && if_b.wen_o) begin
      if (q_b.size() == 0) check("b_unexpected_write", 64'(if_b.data_o), 64'hffff_ffff);
      else begin
        e = q_b.pop_front();
        check("b_beat", 64'({if_b.last_o, 32'(if_b.data_o)}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && if_c.wen_o) begin
      if (q_c.size() == 0) check("c_unexpected_write", 64'(if_c.data_o), 64'hffff_ffff);
      else begin
        e = q_c.pop_front();
        check("c_beat", 64'({if_c.last_o, 32'(if_c.data_o)}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && if_d.wen_o) begin
      if (q_d.size() == 0) check("d_unexpected_write", 64'(if_d.data_o), 64'hffff_ffff);
      else begin
        e = q_d.pop_front();
        check("d_beat", 64'({if_d.last_o, 32'(if_d.data_o)}), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_a.valid_i = 1'b0; if_a.data_i = '0; if_a.full_i = 1'b0;
    if_b.valid_i = 1'b0; if_b.data_i = '0; if_b.full_i = 1'b0;
    if_c.valid_i = 1'b0; if_c.data_i = '0; if_c.full_i = 1'b0;
    if_d.valid_i = 1'b0; if_d.data_i = '0; if_d.full_i = 1'b0;

    // Reset state
    cyc(1);
    checkb("rst_ready_a", if_a.ready_o, 1'b0);
    checkb("rst_ready_d", if_d.ready_o, 1'b0);
    checkb("rst_wen_a", if_a.wen_o, 1'b0);
    checkb("rst_last_a", if_a.last_o, 1'b0);
    check("rst_data_c", 64'(if_c.data_o), 64'd0);
    checkb("rst_busy_any", busy_a | busy_b | busy_c | busy_d, 1'b0);
    cyc(1);
    rst_n = 1'b1;
    #1;
    checkb("post_rst_ready_a", if_a.ready_o, 1'b1);
    checkb("post_rst_ready_c", if_c.ready_o, 1'b1);

    // LSW-first, single lane
    cyc(1);
    if_a.valid_i = 1'b1; if_a.data_i = 32'haf_10_14_36;
    q_a.push_back({1'b0, 32'h36}); q_a.push_back({1'b0, 32'h14});
    q_a.push_back({1'b0, 32'h10}); q_a.push_back({1'b1, 32'haf});
    cyc(1);
    if_a.valid_i = 1'b0;
    checkb("a_busy_after_accept", busy_a, 1'b1);
    checkb("a_ready_beat0", if_a.ready_o, 1'b0);
    cyc(4);
    checkb("a_idle_ready", if_a.ready_o, 1'b1);
    check("a_drain", 64'(q_a.size()), 64'd0);

    // MSW-first, single lane
    if_b.valid_i = 1'b1; if_b.data_i = 32'h11_01_a1_11;
    q_b.push_back({1'b0, 32'h11}); q_b.push_back({1'b0, 32'h01});
    q_b.push_back({1'b0, 32'ha1}); q_b.push_back({1'b1, 32'h11});
    cyc(1);
    if_b.valid_i = 1'b0;
    cyc(4);
    checkb("b_idle_ready", if_b.ready_o, 1'b1);
    check("b_drain", 64'(q_b.size()), 64'd0);

    // Two lanes, back-to-back vectors
    if_c.valid_i = 1'b1; if_c.data_i = 32'haf_10_14_36;
    q_c.push_back({1'b0, 32'h1436}); q_c.push_back({1'b1, 32'haf10});
    q_c.push_back({1'b0, 32'ha111}); q_c.push_back({1'b1, 32'h1101});
    cyc(1);
    if_c.data_i = 32'h11_01_a1_11;
    #1;
    checkb("c_wen_beat0", if_c.wen_o, 1'b1);
    checkb("c_ready_beat0", if_c.ready_o, 1'b0);
    cyc(1);
    checkb("c_wen_beat1", if_c.wen_o, 1'b1);
    checkb("c_ready_beat1", if_c.ready_o, 1'b1);
    cyc(1);
    if_c.valid_i = 1'b0;
    checkb("c_no_bubble", if_c.wen_o, 1'b1);
    cyc(1);
    checkb("c_last_v2", if_c.last_o, 1'b1);
    cyc(1);
    checkb("c_idle", busy_c, 1'b0);
    check("c_drain", 64'(q_c.size()), 64'd0);

    // Stall for three cycles during beat 1
    if_a.valid_i = 1'b1; if_a.data_i = 32'haf_10_14_36;
    q_a.push_back({1'b0, 32'h36}); q_a.push_back({1'b0, 32'h14});
    q_a.push_back({1'b0, 32'h10}); q_a.push_back({1'b1, 32'haf});
    cyc(1);
    if_a.valid_i = 1'b0;
    cyc(1);
    if_a.full_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkb("a_stall_wen", if_a.wen_o, 1'b0);
      check("a_stall_data", 64'(if_a.data_o), 64'h14);
      checkb("a_stall_last", if_a.last_o, 1'b0);
      cyc(1);
    end
    if_a.full_i = 1'b0;
    cyc(4);
    check("a_stall_drain", 64'(q_a.size()), 64'd0);

    // Reset mid-vector after beat 1, then a fresh vector
    if_a.valid_i = 1'b1; if_a.data_i = 32'haf_10_14_36;
    q_a.push_back({1'b0, 32'h36}); q_a.push_back({1'b0, 32'h14});
    cyc(1);
    if_a.valid_i = 1'b0;
    cyc(2);
    rst_n = 1'b0;
    #1;
    checkb("a_rst_wen", if_a.wen_o, 1'b0);
    checkb("a_rst_ready", if_a.ready_o, 1'b0);
    check("a_rst_data", 64'(if_a.data_o), 64'd0);
    checkb("a_rst_last", if_a.last_o, 1'b0);
    check("a_rst_drain", 64'(q_a.size()), 64'd0);
    cyc(1);
    rst_n = 1'b1;
    #1;
    checkb("a_rst_release_ready", if_a.ready_o, 1'b1);
    cyc(1);
    if_a.valid_i = 1'b1; if_a.data_i = 32'h11_01_a1_11;
    q_a.push_back({1'b0, 32'h11}); q_a.push_back({1'b0, 32'ha1});
    q_a.push_back({1'b0, 32'h01}); q_a.push_back({1'b1, 32'h11});
    cyc(1);
    if_a.valid_i = 1'b0;
    cyc(4);
    check("a_post_rst_drain", 64'(q_a.size()), 64'd0);

    // Single-beat vectors with continuous valid
    if_d.valid_i = 1'b1; if_d.data_i = 32'h03_02_01_00;
    q_d.push_back({1'b1, 32'h03020100});
    cyc(1);
    if_d.data_i = 32'h13_12_11_10;
    q_d.push_back({1'b1, 32'h13121110});
    #1;
    checkb("d_ready_0", if_d.ready_o, 1'b1);
    checkb("d_last_0", if_d.last_o, 1'b1);
    cyc(1);
    if_d.data_i = 32'hde_ad_be_ef;
    q_d.push_back({1'b1, 32'hdeadbeef});
    #1;
    checkb("d_ready_1", if_d.ready_o, 1'b1);
    checkb("d_wen_1", if_d.wen_o, 1'b1);
    cyc(1);
    if_d.valid_i = 1'b0;
    checkb("d_wen_2", if_d.wen_o, 1'b1);
    checkb("d_ready_2", if_d.ready_o, 1'b1);
    cyc(1);
    checkb("d_idle", busy_d, 1'b0);
    check("d_drain", 64'(q_d.size()), 64'd0);

    cyc(2);
    check("final_queues", 64'(q_a.size() + q_b.size() + q_c.size() + q_d.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fc_vector_serializer.md
# fc_vector_serializer

Parametrised successor to the fully-connected layer's output serializer. Captures one full layer vector (`LAYER_HEIGHT` words) through a valid/ready handshake and drains it into a downstream FIFO write port, `LANES` words per write beat. It adds three things to the single-word serializer: selectable word order, a `last_o` end-of-vector marker, and zero-bubble back-to-back vectors. It sits between an `fc_layer` output and the FIFO feeding the next layer.

## Interface
- `WORD_SIZE`, 8: bits per word.
- `LAYER_HEIGHT`, 4: words per input vector; ≥1.
- `LANES`, 1: words per FIFO write beat; must divide `LAYER_HEIGHT` (elaboration `$error` otherwise).
- `MSW_FIRST`, 0: 0 = word 0 sent first; 1 = highest-index beat sent first.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `reset_i` in 1: asynchronous, active-low (0 = reset).
- `valid_i` in 1: upstream vector valid.
- `ready_o` out 1: serializer can accept a vector this cycle.
- `data_i` in [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]: vector; word i = `data_i[i]`.
- `wen_o` out 1: FIFO write strobe; a write occurs on every cycle it is 1.
- `full_i` in 1: downstream FIFO full.
- `data_o` out [LANES-1:0][WORD_SIZE-1:0]: current beat.
- `last_o` out 1: current beat is the vector's final beat.
- `busy_o` out 1: a vector is held (state SEND).

## Operation
- `BEATS = LAYER_HEIGHT/LANES`. Beat counter width is `max(1,$clog2(BEATS))`.
- States: IDLE and SEND.
  - IDLE: `ready_o=1`. On `valid_i & ready_o`, latch `data_i`, clear beat counter, go to SEND.
  - SEND: `wen_o = !full_i`. Counter advances only on write cycles.
  - On a write of the final beat: if `valid_i`, latch the new vector and stay in SEND with counter 0. Otherwise go to IDLE.
- `ready_o` = IDLE, or (SEND & final beat & !full_i). This is combinational from `full_i`. A vector is never accepted while one is still undrained.
- Beat mapping, lane l of beat b:
  - `MSW_FIRST=0`: word `b*LANES+l`.
  - `MSW_FIRST=1`: word `(BEATS-1-b)*LANES+l`.
  - Lane order within a beat is never reversed.
- `data_o` and `last_o` are driven from the held vector and counter in SEND. They are 0 in IDLE.
- `last_o` = SEND & counter==BEATS-1, independent of `full_i`.
- `busy_o` = SEND.
- Data is not modified; no arithmetic on words.

## Timing
- Reset (`reset_i=0`, async):
  - state → IDLE, counter 0, held vector 0.
  - While in reset, outputs are `ready_o=0`, `wen_o=0`, `data_o=0`, `last_o=0`, `busy_o=0`.
  - `ready_o` rises combinationally after deassertion.
- Latency: vector accepted at edge N; first write strobe in cycle N+1 if `!full_i`.
- Throughput: with `full_i=0` and continuous `valid_i`, `wen_o` stays high every cycle; `BEATS` cycles per vector, no bubble.
- `full_i` stalls: `wen_o` drops the same cycle. Counter, `data_o` and `last_o` hold until `full_i` falls.
- Simultaneous final write and new accept: both happen on the same edge. The next cycle shows beat 0 of the new vector.
- `valid_i` with `ready_o=0`: ignored. Upstream must hold `valid_i` and `data_i`; the serializer never drops a vector.
- `BEATS=1`: every SEND beat is last; back-to-back accepts every cycle.
- Reset asserted mid-vector: remaining beats are discarded; no further `wen_o`.

## Structure
- Shared package `fc_pkg` holds the state enum `fc_ser_state_e` {IDLE, SEND}. It is shared with future fc blocks.
- One natural sub-module: `fc_beat_counter`.
  - Parameter `COUNT`.
  - Ports: `clk_i`, `reset_i`, `clr_i`, `en_i`, `count_o`, `last_o`.
  - Reused by the deserializer.
- Top contains the FSM, the vector register and the beat mux.

## Test plan
- W=8, H=4, L=1, MSW_FIRST=0, `data_i=32'haf_10_14_36`, `full_i=0` → writes 36,14,10,af on 4 consecutive cycles starting cycle after accept; `last_o` only with af; then IDLE, `ready_o=1`.
- Same config, MSW_FIRST=1, `data_i=32'h11_01_a1_11` → writes 11,01,a1,11 in word order 3,2,1,0.
- L=2, `32'haf_10_14_36` then `32'h11_01_a1_11` back-to-back → beats {14,36},{af,10},{a1,11},{11,01} on 4 consecutive cycles, no bubble; `ready_o` high on the 2nd beat cycle.
- `full_i` asserted 3 cycles during beat 1 → `wen_o=0` for those 3 cycles; `data_o` holds word 1; all 4 words delivered exactly once.
- `reset_i` pulsed low after beat 1 → `wen_o`, `ready_o`, `data_o`, `last_o` go 0 immediately; after release `ready_o=1` and a new vector streams from word 0.
- H=4, L=4 (BEATS=1), continuous `valid_i` → one write per cycle with `last_o=1` every write; `ready_o` stays 1.
